// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control decode: ALUop classes, R-type funct
// codes and the 3-bit ALU select encoding.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_SUB = 3'b110;
  localparam logic [2:0] SEL_SLT = 3'b111;
  localparam logic [2:0] SEL_NOR = 3'b100;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational R-type funct decoder: funct -> {select, illegal}.
// Optional feature: define ALU_CTRL_NOR_EN to accept funct 100111 as NOR;
// without it that code is treated as unsupported.
module alu_funct_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] select,
  output logic       illegal
);

  // Exact six-bit match of funct; anything unrecognised falls back to ADD and flags illegal
  always_comb begin
    select  = SEL_ADD;
    illegal = 1'b0;
    case (funct)
      FN_ADD: select = SEL_ADD;
      FN_SUB: select = SEL_SUB;
      FN_AND: select = SEL_AND;
      FN_OR:  select = SEL_OR;
      FN_SLT: select = SEL_SLT;
`ifdef ALU_CTRL_NOR_EN
      FN_NOR: select = SEL_NOR;
`endif
      default: begin
        select  = SEL_ADD;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_control.sv
// ALU control: selects the ALU operation from the main-decoder ALUop and the
// R-type funct field, registered with one cycle of latency.
// Optional feature: ALU_CTRL_NOR_EN (handled inside alu_funct_decode).
module alu_control
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ALUop,
  input  logic [5:0] function_bit,
  input  logic       in_valid,
  output logic [2:0] select,
  output logic       out_valid,
  output logic       illegal
);

  logic [2:0] fn_sel_p0;
  logic       fn_ill_p0;
  logic [2:0] sel_p0;
  logic       ill_p0;
  logic [2:0] sel_p1;
  logic       ill_p1;
  logic       vld_p1;

  alu_funct_decode u_funct_decode (
    .funct   (function_bit),
    .select  (fn_sel_p0),
    .illegal (fn_ill_p0)
  );

  // ALUop mux: only the R-type class consults the funct decoder, so illegal
  // cannot be raised for any other class
  always_comb begin
    sel_p0 = SEL_ADD;
    ill_p0 = 1'b0;
    case (ALUop)
      ALUOP_MEM: sel_p0 = SEL_ADD;
      ALUOP_BR:  sel_p0 = SEL_SUB;
      ALUOP_R: begin
        sel_p0 = fn_sel_p0;
        ill_p0 = fn_ill_p0;
      end
      default:   sel_p0 = SEL_ADD;
    endcase
  end

  // ---- p0 -> p1 stage boundary ----
  // Output register: load on valid input, otherwise drop valid and hold data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_p1 <= SEL_ADD;
      ill_p1 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (in_valid) begin
      sel_p1 <= sel_p0;
      ill_p1 <= ill_p0;
      vld_p1 <= 1'b1;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign select    = sel_p1;
  assign illegal   = ill_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed cases followed by randomized
// traffic checked against a table-driven reference model.
module tb_alu_control;

  logic       clk;
  logic       rst_n;
  logic [1:0] ALUop;
  logic [5:0] function_bit;
  logic       in_valid;
  logic [2:0] select;
  logic       out_valid;
  logic       illegal;

  int checks;
  int failures;

  logic [2:0] exp_sel;
  logic       exp_ill;
  logic       exp_vld;

  // Reference table of supported R-type funct values (decimal) and their select codes
  int fn_tab  [6] = '{32, 34, 36, 37, 42, 39};
  int sel_tab [6] = '{ 2,  6,  0,  1,  7,  4};
`ifdef ALU_CTRL_NOR_EN
  int n_supported = 6;
`else
  int n_supported = 5;
`endif

  alu_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ALUop        (ALUop),
    .function_bit (function_bit),
    .in_valid     (in_valid),
    .select       (select),
    .out_valid    (out_valid),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  // Reference decode: memory -> add (2), branch -> sub (6), R-type by table, reserved -> add
  task automatic ref_decode(input int op, input int fn, output int sel, output int ill);
    sel = 2;
    ill = 0;
    if (op == 1) sel = 6;
    else if (op == 2) begin
      ill = 1;
      for (int i = 0; i < n_supported; i++)
        if (fn_tab[i] == fn) begin
          sel = sel_tab[i];
          ill = 0;
        end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".select"},    select,    exp_sel);
    check({tag, ".illegal"},   illegal,   exp_ill);
    check({tag, ".out_valid"}, out_valid, exp_vld);
  endtask

  task automatic step(input logic [1:0] op, input logic [5:0] fn, input logic v, input string tag);
    int s, il;
    @(negedge clk);
    ALUop = op;
    function_bit = fn;
    in_valid = v;
    @(posedge clk);
    #1;
    if (v) begin
      ref_decode(op, fn, s, il);
      exp_sel = s[2:0];
      exp_ill = il[0];
      exp_vld = 1'b1;
    end else begin
      exp_vld = 1'b0;
    end
    check_outputs(tag);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    ALUop = 2'b00;
    function_bit = 6'd0;
    in_valid = 1'b0;
    exp_sel = 3'b010;
    exp_ill = 1'b0;
    exp_vld = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step(2'b00, 6'b100000, 1'b1, "mem_add");
    step(2'b01, 6'b100000, 1'b1, "br_sub");
    step(2'b01, 6'b000000, 1'b0, "idle_hold");
    step(2'b10, 6'b100000, 1'b1, "r_add");
    step(2'b10, 6'b100010, 1'b1, "r_sub");
    step(2'b10, 6'b100100, 1'b1, "r_and");
    step(2'b10, 6'b100101, 1'b1, "r_or");
    step(2'b10, 6'b101010, 1'b1, "r_slt");
    step(2'b10, 6'b111111, 1'b1, "r_bad");
    step(2'b00, 6'b111111, 1'b1, "mem_bad_fn");
    step(2'b10, 6'b100111, 1'b1, "r_nor");
    step(2'b11, 6'b111111, 1'b1, "reserved");
    step(2'b10, 6'b000000, 1'b1, "r_zero");
    step(2'b10, 6'b111111, 1'b1, "r_bad2");
    step(2'b10, 6'b100000, 1'b0, "idle_after_ill");

    // Asynchronous reset asserted mid-cycle with valid traffic present
    @(negedge clk);
    ALUop = 2'b10;
    function_bit = 6'b101010;
    in_valid = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_sel = 3'b010;
    exp_ill = 1'b0;
    exp_vld = 1'b0;
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b01, 6'b000000, 1'b1, "post_rst");

    // Randomized traffic, half the R-type funct values drawn from the supported set
    for (int n = 0; n < 400; n++) begin
      logic [1:0] op;
      logic [5:0] fn;
      logic v;
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) fn = 6'(fn_tab[$urandom_range(0, 5)]);
      else fn = 6'($urandom);
      v = ($urandom_range(0, 3) != 0);
      step(op, fn, v, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
